// File: rtl/uart_reg_bank.sv
// UART-side coefficient register bank: parses checksummed read/write frames,
// commits writes, and replies with ACK/NAK or read data plus checksum.
module uart_reg_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 100000
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          update,
  output logic                         frame_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CSUM, S_EXEC, S_TX_ACK, S_TX_DATA, S_TX_CSUM
  } state_t;

  state_t              state_q;
  logic [7:0]          hdr_q;
  logic [7:0]          acc_q;
  logic [DATA_W-1:0]   stage_q;
  logic [3:0]          bcnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                nak_q;
  logic [DATA_W-1:0]   txsh_q;
  logic [7:0]          txcs_q;
  logic [7:0]          tx_byte_q;
  logic                tx_valid_q;
  logic [NUM_REGS-1:0] update_q;
  logic                frame_err_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                addr_ok;
  logic                expired;
  logic [DATA_W-1:0]   rd_data;
  logic [7:0]          rd_csum;

  assign addr_ok = ({1'b0, hdr_q[6:0]} < 8'(NUM_REGS));
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    rd_data = '0;
    rd_csum = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (hdr_q[6:0] == 7'(k)) rd_data = regs_q[k];
    end
    for (int unsigned b = 0; b < NBYTES; b++) begin
      rd_csum = rd_csum ^ rd_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      acc_q       <= '0;
      stage_q     <= '0;
      bcnt_q      <= '0;
      cnt_q       <= '0;
      nak_q       <= 1'b0;
      txsh_q      <= '0;
      txcs_q      <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      update_q    <= '0;
      frame_err_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      update_q    <= '0;
      frame_err_q <= 1'b0;
      // Bytes arriving while a reply is pending are dropped as overruns.
      if (rx_valid && (state_q inside {S_EXEC, S_TX_ACK, S_TX_DATA, S_TX_CSUM}))
        frame_err_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            hdr_q   <= rx_byte;
            acc_q   <= rx_byte;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            nak_q   <= 1'b0;
            state_q <= rx_byte[7] ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            stage_q <= (stage_q << 8) | DATA_W'(rx_byte);
            acc_q   <= acc_q ^ rx_byte;
            cnt_q   <= '0;
            bcnt_q  <= bcnt_q + 4'd1;
            if (bcnt_q == 4'(NBYTES - 1)) state_q <= S_CSUM;
          end else if (expired) begin
            state_q     <= S_IDLE;
            frame_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CSUM: begin
          // Decision and commit happen on the checksum edge so the register
          // and its update pulse are visible during the EXEC cycle.
          if (rx_valid) begin
            cnt_q   <= '0;
            state_q <= S_EXEC;
            if (rx_byte != acc_q || !addr_ok) begin
              nak_q       <= 1'b1;
              frame_err_q <= 1'b1;
            end else if (!hdr_q[7]) begin
              for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (hdr_q[6:0] == 7'(k)) begin
                  regs_q[k]   <= stage_q;
                  update_q[k] <= 1'b1;
                end
              end
            end
          end else if (expired) begin
            state_q     <= S_IDLE;
            frame_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          tx_valid_q <= 1'b1;
          if (nak_q) begin
            tx_byte_q <= NAK;
            state_q   <= S_TX_ACK;
          end else if (!hdr_q[7]) begin
            tx_byte_q <= ACK;
            state_q   <= S_TX_ACK;
          end else begin
            tx_byte_q <= rd_data[DATA_W-1 -: 8];
            txsh_q    <= rd_data << 8;
            txcs_q    <= rd_csum;
            bcnt_q    <= '0;
            state_q   <= S_TX_DATA;
          end
        end
        S_TX_DATA: begin
          if (tx_ready) begin
            if (bcnt_q == 4'(NBYTES - 1)) begin
              tx_byte_q <= txcs_q;
              state_q   <= S_TX_CSUM;
            end else begin
              tx_byte_q <= txsh_q[DATA_W-1 -: 8];
              txsh_q    <= txsh_q << 8;
              bcnt_q    <= bcnt_q + 4'd1;
            end
          end
        end
        S_TX_ACK, S_TX_CSUM: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign update    = update_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Bench for uart_reg_bank: directed frames plus randomized frames checked
// against an array-based model of the register file and reply rules.
module tb_uart_reg_bank;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int TO = 60;
  localparam int NB = DW / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic [7:0]       tx_byte;
  logic             tx_valid;
  logic             tx_ready;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0]    update;
  logic             frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] mregs [NR];

  always #5 clk = ~clk;

  uart_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .TIMEOUT(TO)) dut (
    .clk_in(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .regs(regs), .update(update), .frame_err(frame_err)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = mregs[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 5 cycles first
  task automatic collect(input logic [7:0] exp [4], input int n, input int mode, input string name);
    int got = 0;
    int cyc = 0;
    logic r;
    logic stalled = 1'b0;
    logic [7:0] prev = '0;
    while (got < n && cyc < 300) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 2) r = (cyc >= 5);
      else r = 1'($urandom_range(0, 1));
      tx_ready = r;
      if (stalled) begin
        n_tests++;
        if (tx_valid !== 1'b1 || tx_byte !== prev) begin
          n_fail++;
          $display("FAIL %s hold: tx_valid=%b tx_byte=%h, required 1/%h", name, tx_valid, tx_byte, prev);
        end
      end
      if (tx_valid && r) begin
        n_tests++;
        if (tx_byte !== exp[got]) begin
          n_fail++;
          $display("FAIL %s byte%0d: got %h, required %h", name, got, tx_byte, exp[got]);
        end
        got++;
      end
      stalled = tx_valid && !r;
      prev = tx_byte;
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    n_tests++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s reply_count: got %0d bytes, required %0d", name, got, n);
    end
    if (mode == 0) begin
      n_tests++;
      if (cyc != n) begin
        n_fail++;
        $display("FAIL %s back_to_back: took %0d cycles, required %0d", name, cyc, n);
      end
    end
    n_tests++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s tx_valid_end: got %b, required 0", name, tx_valid);
    end
  endtask

  task automatic do_frame(input bit rd, input logic [6:0] addr, input logic [DW-1:0] data,
                          input logic [7:0] cmask, input int gmax, input int mode, input string name);
    logic [7:0] fb [4];
    logic [7:0] exp [4];
    logic [7:0] h, x, b;
    logic [DW-1:0] v;
    logic [NR-1:0] eu;
    int nb, ne;
    bit valid;
    h = {rd, addr};
    fb = '{default: 8'h00};
    exp = '{default: 8'h00};
    fb[0] = h;
    nb = 1;
    x = h;
    if (!rd) begin
      for (int i = 0; i < NB; i++) begin
        b = data[DW-1-8*i -: 8];
        fb[nb] = b;
        nb++;
        x = x ^ b;
      end
    end
    fb[nb] = x ^ cmask;
    nb++;
    valid = (cmask == 8'h00) && (addr < NR);
    eu = '0;
    if (!valid) begin
      exp[0] = 8'h15;
      ne = 1;
    end else if (!rd) begin
      mregs[addr[1:0]] = data;
      eu[addr[1:0]] = 1'b1;
      exp[0] = 8'h06;
      ne = 1;
    end else begin
      v = mregs[addr[1:0]];
      x = 8'h00;
      for (int i = 0; i < NB; i++) begin
        exp[i] = v[DW-1-8*i -: 8];
        x = x ^ exp[i];
      end
      exp[NB] = x;
      ne = NB + 1;
    end
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gmax)) tick();
      send_byte(fb[i]);
    end
    n_tests += 4;
    if (update !== eu) begin
      n_fail++;
      $display("FAIL %s update: got %b, required %b", name, update, eu);
    end
    if (frame_err !== !valid) begin
      n_fail++;
      $display("FAIL %s frame_err: got %b, required %b", name, frame_err, !valid);
    end
    if (regs !== model_vec()) begin
      n_fail++;
      $display("FAIL %s regs: got %h, required %h", name, regs, model_vec());
    end
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early_tx: got %b, required 0", name, tx_valid);
    end
    tick();
    n_tests += 2;
    if (tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tx_start: got %b, required 1", name, tx_valid);
    end
    if (update !== '0) begin
      n_fail++;
      $display("FAIL %s update_pulse: got %b, required 0", name, update);
    end
    collect(exp, ne, mode, name);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0; tx_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (regs !== '0 || tx_valid !== 1'b0 || tx_byte !== 8'h00 || update !== '0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: regs=%h txv=%b txb=%h upd=%b ferr=%b, required all 0",
               regs, tx_valid, tx_byte, update, frame_err);
    end
    reset = 1'b0;
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    tick();
  endtask

  task automatic test_write_read();
    do_frame(1'b0, 7'd2, 16'h1234, 8'h00, 0, 1, "write_r2");
    do_frame(1'b1, 7'd2, 16'h0000, 8'h00, 0, 2, "read_r2_stall");
  endtask

  task automatic test_bad_frames();
    do_frame(1'b0, 7'd1, 16'hABCD, 8'h67, 0, 1, "bad_csum");
    do_frame(1'b0, 7'd5, 16'h0001, 8'h00, 0, 1, "bad_addr");
    do_frame(1'b1, 7'd100, 16'h0000, 8'h00, 1, 1, "bad_addr_rd");
  endtask

  task automatic test_timeout();
    int first = -1;
    bit saw_tx = 1'b0;
    send_byte(8'h00);
    send_byte(8'h11);
    for (int i = 1; i <= TO + 5; i++) begin
      tick();
      if (frame_err && first < 0) first = i;
      if (tx_valid) saw_tx = 1'b1;
    end
    n_tests += 3;
    if (first < TO - 1 || first > TO + 1) begin
      n_fail++;
      $display("FAIL timeout_err: pulse at cycle %0d, required %0d", first, TO);
    end
    if (saw_tx) begin
      n_fail++;
      $display("FAIL timeout_tx: got a reply, required none");
    end
    if (regs !== model_vec()) begin
      n_fail++;
      $display("FAIL timeout_regs: got %h, required %h", regs, model_vec());
    end
    do_frame(1'b0, 7'd0, 16'h5AA5, 8'h00, 0, 1, "after_timeout");
  endtask

  task automatic test_overrun();
    logic [7:0] exp [4];
    logic [DW-1:0] v;
    v = mregs[2];
    exp = '{v[15:8], v[7:0], v[15:8] ^ v[7:0], 8'h00};
    send_byte(8'h82);
    send_byte(8'h82);
    rx_byte = 8'h5A; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    n_tests += 2;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_exec: frame_err=%b, required 1", frame_err);
    end
    if (tx_valid !== 1'b1 || tx_byte !== exp[0]) begin
      n_fail++;
      $display("FAIL overrun_exec_tx: %b/%h, required 1/%h", tx_valid, tx_byte, exp[0]);
    end
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    n_tests += 2;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_tx: frame_err=%b, required 1", frame_err);
    end
    if (tx_byte !== exp[0]) begin
      n_fail++;
      $display("FAIL overrun_hold: tx_byte=%h, required %h", tx_byte, exp[0]);
    end
    tick();
    n_tests++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_pulse: frame_err=%b, required 0", frame_err);
    end
    collect(exp, 3, 1, "overrun_reply");
  endtask

  task automatic test_back_to_back();
    do_frame(1'b1, 7'd2, 16'h0000, 8'h00, 0, 0, "b2b_read");
    do_frame(1'b0, 7'd3, 16'($urandom), 8'h00, 0, 0, "b2b_write");
    do_frame(1'b1, 7'd3, 16'h0000, 8'h00, 0, 0, "b2b_readback");
  endtask

  task automatic test_random();
    logic [7:0] cm;
    for (int i = 0; i < 60; i++) begin
      cm = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 16'($urandom),
               cm, 3, 1, "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h03);
    send_byte(8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    n_tests++;
    if (regs !== '0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: regs=%h txv=%b, required 0/0", regs, tx_valid);
    end
    do_frame(1'b1, 7'd3, 16'h0000, 8'h00, 0, 1, "read_after_reset");
    do_frame(1'b0, 7'd1, 16'hBEEF, 8'h00, 0, 1, "write_r1");
    send_byte(8'h81);
    send_byte(8'h81);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    n_tests++;
    if (regs !== '0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_reply: regs=%h txv=%b, required 0/0", regs, tx_valid);
    end
    do_frame(1'b1, 7'd1, 16'h0000, 8'h00, 0, 0, "read_r1_after_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bad_frames();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_bank.md
# uart_reg_bank

Parametrised UART-side register bank that sits between the UART byte interface and the PID datapath, replacing the single-coefficient memory path. Parses framed, checksummed read/write commands from received bytes, holds NUM_REGS coefficient registers of DATA_W bits, and replies with ACK/NAK or read data through the UART transmit handshake. Adds readback, error detection and inter-byte timeout, none of which the single-register path provides.

## Interface
- DATA_W, 16, register width in bits; multiple of 8, range 8..64; NBYTES = DATA_W/8
- NUM_REGS, 4, number of registers; range 1..128
- TIMEOUT, 100000, max clk_in cycles between bytes of one frame before abort
- clk_in  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_byte  input  8  received byte, valid when rx_valid
- rx_valid  input  1  one-cycle strobe per received byte
- tx_byte  output  8  byte to transmit
- tx_valid  output  1  tx_byte valid; held until accepted
- tx_ready  input  1  transmitter accepts tx_byte when tx_valid && tx_ready
- regs  output  NUM_REGS*DATA_W  flattened registers; reg k at [k*DATA_W +: DATA_W]
- update  output  NUM_REGS  one-cycle pulse on bit k when reg k is committed
- frame_err  output  1  one-cycle pulse on checksum error, bad address, timeout or overrun

## Operation
- Header byte: bit7 = R (1 read, 0 write), bits6:0 = address.
- Write frame: header, NBYTES data bytes MSB first, checksum = XOR of header and all data bytes.
- Read frame: header, checksum = header.
- Running XOR accumulator cleared on header capture; data shifted into a DATA_W staging register.
- States: IDLE -> (rx_valid) capture header -> DATA (write) or CSUM (read); DATA -> CSUM after NBYTES bytes; CSUM -> (rx_valid) EXEC; EXEC -> TX_ACK or TX_DATA; TX_DATA -> TX_CSUM after NBYTES accepted; TX_ACK / TX_CSUM -> IDLE on acceptance.
- EXEC: checksum mismatch or address >= NUM_REGS -> tx_byte = 0x15 (NAK), frame_err pulse, no register change. Valid write -> commit staging to reg, update[addr] pulse, tx_byte = 0x06 (ACK). Valid read -> transmit reg MSB byte first, then XOR of the data bytes.
- Overrun: rx_valid during EXEC/TX_* states drops the byte and pulses frame_err; state unaffected.
- Timeout: in DATA/CSUM a counter increments each cycle, clears on rx_valid; on reaching TIMEOUT -> IDLE, frame_err pulse, no reply, no commit.
- Reset: regs = 0, update = 0, tx_valid = 0, tx_byte = 0, frame_err = 0, state IDLE, counters 0. Reset mid-frame or mid-reply discards everything; no partial commit.

## Timing
- Checksum byte strobe at cycle N: EXEC at N+1; reg and update[addr] visible at N+1 output (registered commit on the N+1 edge, update high for exactly one cycle); tx_valid high from N+2.
- tx_byte and tx_valid stable while tx_valid && !tx_ready; next byte presented the cycle after acceptance (one byte per two cycles min, or back-to-back if tx_ready held high: next byte on the cycle after the accepting edge).
- tx_valid deasserts the cycle after the final byte is accepted; header of next frame accepted in IDLE that same cycle onward.
- rx_valid and timeout expiry in the same cycle: byte wins, counter clears.
- Registers never change except on a valid write commit or reset.

## Test plan
- Write reg 2 = 0x1234: rx 0x02,0x12,0x34,0x24 -> regs[47:32] = 0x1234, update = 4'b0100 one cycle, tx 0x06; other regs 0.
- Read reg 2 after above: rx 0x82,0x82 -> tx 0x12,0x34,0x26 in order; with tx_ready low for 5 cycles, tx_byte holds 0x12.
- Bad checksum: rx 0x01,0xAB,0xCD,0x00 -> tx 0x15, frame_err pulse, regs[31:16] unchanged, update = 0.
- Bad address: rx 0x05,0x00,0x01,0x04 with NUM_REGS = 4 -> tx 0x15, frame_err, no update.
- Timeout: rx 0x00,0x11 then silence TIMEOUT cycles -> frame_err pulse, no tx; subsequent valid write to reg 0 succeeds with ACK.
- Reset mid-frame: rx 0x03,0xFF then reset one cycle -> all regs 0, tx_valid 0; following rx 0x83,0x83 -> tx 0x00,0x00,0x00.
